hilo_unit: RTL and testbench
============================

Name: hilo_unit

Overview:
- HI/LO architectural register block that sits directly downstream of the EX-stage multiply/divide unit.
- Captures the 64-bit mult/div result, or MTHI/MTLO data, and carries each pending write through MEM and WB shadow stages before commit.
- Supplies MFHI/MFLO reads with forwarding.
- Supports MADD/MSUB accumulation.
- Raises a stall request while a mult/div is outstanding.

Parameters:
- DW, 32, data word width; HI and LO are each DW bits, the result is 2*DW bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- stall_all  in  1  global freeze; no state changes while high
- flush  in  1  kill instructions in EX and MEM
- md_start  in  1  EX issues MULT/MULTU/DIV/DIVU/MADD/MSUB this cycle
- md_op  in  2  accumulate mode: 00 = write, 01 = add (MADD), 10 = sub (MSUB), 11 = reserved (treated as 00)
- md_done  in  1  mult/div result valid; held by the multiplier while stall_all is high
- md_result  in  2*DW  {hi,lo} result from the multiplier
- mt_we_hi  in  1  MTHI in EX
- mt_we_lo  in  1  MTLO in EX
- mt_data  in  DW  MTHI/MTLO source operand
- rd_req  in  1  MFHI/MFLO in EX
- rd_sel  in  1  0 = LO, 1 = HI
- rd_data  out  DW  forwarded HI/LO value
- stall_req  out  1  pipeline stall request
- hi  out  DW  architectural HI
- lo  out  DW  architectural LO

Behaviour:
- Reset (rst = 0, asynchronous):
  - hi and lo clear to 0.
  - s1/s2 valid bits clear to 0.
  - busy clears to 0.
  - stall_req and rd_data read 0.
- Busy flag:
  - Sets on md_start & ~stall_all & ~flush.
  - Clears on md_done & ~stall_all.
  - md_done arriving while busy = 0 is ignored.
  - md_start while busy = 1 is ignored; stall_req covers this case.
- stall_req is combinational: busy & (rd_req | md_start | mt_we_hi | mt_we_lo).
- Latched md_op: captured at md_start and used when md_done arrives.
- Entry formation (EX-side), when ~stall_all and any of md_done (while busy), mt_we_hi or mt_we_lo is asserted:
  - Base value F = forwarded 64-bit {hi,lo}, priority s1 > s2 > architectural.
  - If md_done: V = md_result (op 00), F + md_result (op 01), or F − md_result (op 10). Arithmetic is 2*DW bits modulo 2^(2*DW); carry/borrow is discarded.
  - Otherwise V = F.
  - mt_we_hi replaces V[2DW-1:DW] with mt_data; mt_we_lo replaces V[DW-1:0] with mt_data. MT is the younger instruction and wins over a simultaneous md_done.
  - The entry is loaded into s1 at the next edge with s1_valid = 1.
- Pipeline movement on each edge with stall_all = 0:
  - s2 <= s1.
  - If s2_valid, {hi,lo} <= s2.
  - s1 <= new entry, or invalid if there is none.
- Commit latency: a write formed in cycle N is visible on hi/lo after the edge ending cycle N+2. rd_data sees it from cycle N+1 via forwarding.
- rd_data (combinational): the selected half of F.
  - A same-cycle EX write is NOT forwarded; program order makes this impossible.
  - rd_data = 0 when rd_req = 0.
- stall_all = 1: every register holds and nothing commits. md_done is not consumed, and busy is unchanged.
- flush = 1 (stall_all = 0):
  - s1 is invalidated instead of advancing.
  - Any new EX entry is dropped.
  - busy clears, and a later md_done for the killed op is ignored.
  - s2 still commits, because WB is older than the faulting instruction.
- Simultaneous md_done and flush: the result is dropped.
- Reset mid-operation: all state clears immediately. A pending md_done after reset is ignored because busy = 0.

Test Plan:
- Basic write: reset, md_start; 3 cycles later md_done with md_result = 64'h0000_0001_FFFF_FFFE, md_op = 00 → hi = 1 and lo = 32'hFFFF_FFFE two edges after done; an MFHI issued the cycle after done returns 1.
- Stall on busy: md_start, then rd_req = 1 the next cycle → stall_req = 1 every cycle until md_done; rd_data then returns the new value with no stale read.
- MADD/MSUB wrap: hi/lo = 32'hFFFF_FFFF/32'hFFFF_FFFF, MADD result 64'h1 → {hi,lo} = 0. Then MSUB 64'h1 → all ones.
- MTLO forwarding chain: MTLO 32'hA5A5 followed back-to-back by MTHI 32'h5A5A, then MFLO → rd_data = 32'hA5A5 from s1/s2; architectural lo updates two edges after the MTLO.
- Flush: MTHI 7 commits to s2, MTHI 9 sits in s1, flush → hi = 7 and the 9 is lost. md_start followed by flush, then md_done → hi/lo unchanged and busy = 0.
- stall_all and reset: stall_all held 4 cycles with s1/s2 valid → no commit and hi/lo stable; commit resumes after release. rst low mid-divide → all outputs 0 immediately, and a subsequent md_done is ignored.

Source files
------------

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register block with EX/MEM/WB shadow stages, forwarding and MADD/MSUB accumulation
module hilo_unit #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_all,
  input  logic            flush,
  input  logic            md_start,
  input  logic [1:0]      md_op,
  input  logic            md_done,
  input  logic [2*DW-1:0] md_result,
  input  logic            mt_we_hi,
  input  logic            mt_we_lo,
  input  logic [DW-1:0]   mt_data,
  input  logic            rd_req,
  input  logic            rd_sel,
  output logic [DW-1:0]   rd_data,
  output logic            stall_req,
  output logic [DW-1:0]   hi,
  output logic [DW-1:0]   lo
);

  logic            r_busy;
  logic [1:0]      r_op;
  logic [2*DW-1:0] r_s1;
  logic            r_s1_v;
  logic [2*DW-1:0] r_s2;
  logic            r_s2_v;
  logic [DW-1:0]   r_hi;
  logic [DW-1:0]   r_lo;

  logic [2*DW-1:0] w_fwd;
  logic [2*DW-1:0] w_val;
  logic            w_done;
  logic            w_ent;

  // Youngest pending write wins: MEM shadow, then WB shadow, then architectural
  assign w_fwd  = r_s1_v ? r_s1 : (r_s2_v ? r_s2 : {r_hi, r_lo});
  assign w_done = md_done & r_busy;
  assign w_ent  = w_done | mt_we_hi | mt_we_lo;

  always_comb begin
    w_val = w_fwd;
    if (w_done) begin
      case (r_op)
        2'b01:   w_val = w_fwd + md_result;
        2'b10:   w_val = w_fwd - md_result;
        default: w_val = md_result;
      endcase
    end
    // MT is younger than the completing mult/div, so it overrides that half
    if (mt_we_hi) w_val[2*DW-1:DW] = mt_data;
    if (mt_we_lo) w_val[DW-1:0]    = mt_data;
  end

  assign rd_data   = rd_req ? (rd_sel ? w_fwd[2*DW-1:DW] : w_fwd[DW-1:0]) : '0;
  assign stall_req = r_busy & (rd_req | md_start | mt_we_hi | mt_we_lo);
  assign hi        = r_hi;
  assign lo        = r_lo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_op   <= 2'b00;
      r_s1   <= '0;
      r_s1_v <= 1'b0;
      r_s2   <= '0;
      r_s2_v <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else if (!stall_all) begin
      // WB is older than any faulting instruction, so it commits even on flush
      if (r_s2_v) begin
        r_hi <= r_s2[2*DW-1:DW];
        r_lo <= r_s2[DW-1:0];
      end
      r_s2   <= r_s1;
      r_s2_v <= r_s1_v & ~flush;
      r_s1   <= w_val;
      r_s1_v <= w_ent & ~flush;
      if (flush) begin
        r_busy <= 1'b0;
      end else if (r_busy) begin
        if (md_done) r_busy <= 1'b0;
      end else if (md_start) begin
        r_busy <= 1'b1;
        r_op   <= md_op;
      end
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - directed self-checking bench for hilo_unit
module tb_hilo_unit;

  logic        clk;
  logic        rst;
  logic        stall_all;
  logic        flush;
  logic        md_start;
  logic [1:0]  md_op;
  logic        md_done;
  logic [63:0] md_result;
  logic        mt_we_hi;
  logic        mt_we_lo;
  logic [31:0] mt_data;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_pass;
  int n_total;

  hilo_unit #(.DW(32)) dut (
    .clk(clk), .rst(rst), .stall_all(stall_all), .flush(flush),
    .md_start(md_start), .md_op(md_op), .md_done(md_done), .md_result(md_result),
    .mt_we_hi(mt_we_hi), .mt_we_lo(mt_we_lo), .mt_data(mt_data),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data),
    .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_all = 0; flush = 0; md_start = 0; md_op = 2'b00; md_done = 0;
    md_result = 64'h0; mt_we_hi = 0; mt_we_lo = 0; mt_data = 32'h0;
    rd_req = 0; rd_sel = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    rd_req = 1; rd_sel = 1; md_start = 1;
    tick(); tick();
    n_total++; if (hi !== 32'h0) $display("FAIL reset_hi got %h want %h", hi, 32'h0); else n_pass++;
    n_total++; if (lo !== 32'h0) $display("FAIL reset_lo got %h want %h", lo, 32'h0); else n_pass++;
    n_total++; if (stall_req !== 1'b0) $display("FAIL reset_stall got %b want 0", stall_req); else n_pass++;
    n_total++; if (rd_data !== 32'h0) $display("FAIL reset_rd got %h want %h", rd_data, 32'h0); else n_pass++;
    idle();
    rst = 1;
    tick();
  endtask

  task automatic test_basic_write();
    md_start = 1; md_op = 2'b00; tick();
    md_start = 0; tick(); tick();
    md_done = 1; md_result = 64'h0000_0001_FFFF_FFFE; #1;
    n_total++; if (stall_req !== 1'b0) $display("FAIL basic_nostall got %b want 0", stall_req); else n_pass++;
    tick();
    md_done = 0; rd_req = 1; rd_sel = 1; #1;
    n_total++; if (rd_data !== 32'h1) $display("FAIL basic_mfhi got %h want %h", rd_data, 32'h1); else n_pass++;
    n_total++; if (stall_req !== 1'b0) $display("FAIL basic_busy_clr got %b want 0", stall_req); else n_pass++;
    n_total++; if (hi !== 32'h0) $display("FAIL basic_early0 got %h want %h", hi, 32'h0); else n_pass++;
    rd_req = 0; tick();
    n_total++; if (hi !== 32'h0) $display("FAIL basic_early1 got %h want %h", hi, 32'h0); else n_pass++;
    tick();
    n_total++; if (hi !== 32'h1) $display("FAIL basic_hi got %h want %h", hi, 32'h1); else n_pass++;
    n_total++; if (lo !== 32'hFFFF_FFFE) $display("FAIL basic_lo got %h want %h", lo, 32'hFFFF_FFFE); else n_pass++;
  endtask

  task automatic test_stall_on_busy();
    md_start = 1; md_op = 2'b00; tick();
    md_start = 0; rd_req = 1; rd_sel = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (stall_req !== 1'b1) $display("FAIL busy_stall%0d got %b want 1", i, stall_req); else n_pass++;
      tick();
    end
    md_done = 1; md_result = 64'h0000_0002_0000_0003; #1;
    n_total++; if (stall_req !== 1'b1) $display("FAIL busy_stall_done got %b want 1", stall_req); else n_pass++;
    tick();
    md_done = 0; #1;
    n_total++; if (stall_req !== 1'b0) $display("FAIL busy_release got %b want 0", stall_req); else n_pass++;
    n_total++; if (rd_data !== 32'h3) $display("FAIL busy_rd got %h want %h", rd_data, 32'h3); else n_pass++;
    rd_req = 0; tick(); tick();
    n_total++; if ({hi, lo} !== 64'h0000_0002_0000_0003) $display("FAIL busy_commit got %h want %h", {hi, lo}, 64'h0000_0002_0000_0003); else n_pass++;
  endtask

  task automatic test_madd_msub();
    mt_we_hi = 1; mt_we_lo = 1; mt_data = 32'hFFFF_FFFF; tick();
    mt_we_hi = 0; mt_we_lo = 0; tick(); tick();
    n_total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL mt_both got %h want %h", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF); else n_pass++;
    md_start = 1; md_op = 2'b01; tick();
    md_start = 0; md_op = 2'b00; md_done = 1; md_result = 64'h1; tick();
    md_done = 0; tick(); tick();
    n_total++; if ({hi, lo} !== 64'h0) $display("FAIL madd_wrap got %h want %h", {hi, lo}, 64'h0); else n_pass++;
    md_start = 1; md_op = 2'b10; tick();
    md_start = 0; md_op = 2'b00; md_done = 1; md_result = 64'h1; tick();
    md_done = 0; tick(); tick();
    n_total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL msub_wrap got %h want %h", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF); else n_pass++;
    md_start = 1; md_op = 2'b11; tick();
    md_start = 0; md_op = 2'b01; md_done = 1; md_result = 64'h1234_5678_9ABC_DEF0; tick();
    md_done = 0; md_op = 2'b00; tick(); tick();
    n_total++; if ({hi, lo} !== 64'h1234_5678_9ABC_DEF0) $display("FAIL op11_write got %h want %h", {hi, lo}, 64'h1234_5678_9ABC_DEF0); else n_pass++;
  endtask

  task automatic test_mt_forward();
    mt_we_lo = 1; mt_data = 32'h0000_A5A5; tick();
    mt_we_lo = 0; mt_we_hi = 1; mt_data = 32'h0000_5A5A; tick();
    mt_we_hi = 0; rd_req = 1; rd_sel = 0; #1;
    n_total++; if (rd_data !== 32'h0000_A5A5) $display("FAIL mtlo_fwd_s1 got %h want %h", rd_data, 32'h0000_A5A5); else n_pass++;
    n_total++; if (lo !== 32'h9ABC_DEF0) $display("FAIL mtlo_early got %h want %h", lo, 32'h9ABC_DEF0); else n_pass++;
    tick();
    n_total++; if (lo !== 32'h0000_A5A5) $display("FAIL mtlo_commit got %h want %h", lo, 32'h0000_A5A5); else n_pass++;
    n_total++; if (rd_data !== 32'h0000_A5A5) $display("FAIL mtlo_fwd_s2 got %h want %h", rd_data, 32'h0000_A5A5); else n_pass++;
    n_total++; if (hi !== 32'h1234_5678) $display("FAIL mthi_early got %h want %h", hi, 32'h1234_5678); else n_pass++;
    rd_sel = 1; #1;
    n_total++; if (rd_data !== 32'h0000_5A5A) $display("FAIL mthi_fwd got %h want %h", rd_data, 32'h0000_5A5A); else n_pass++;
    rd_req = 0; tick();
    n_total++; if (hi !== 32'h0000_5A5A) $display("FAIL mthi_commit got %h want %h", hi, 32'h0000_5A5A); else n_pass++;
  endtask

  task automatic test_flush();
    mt_we_hi = 1; mt_data = 32'h7; tick();
    mt_data = 32'h9; tick();
    mt_we_hi = 0; flush = 1; mt_we_lo = 1; mt_data = 32'h1111; tick();
    flush = 0; mt_we_lo = 0;
    n_total++; if (hi !== 32'h7) $display("FAIL flush_s2_commit got %h want %h", hi, 32'h7); else n_pass++;
    tick(); tick();
    n_total++; if (hi !== 32'h7) $display("FAIL flush_s1_lost got %h want %h", hi, 32'h7); else n_pass++;
    n_total++; if (lo !== 32'h0000_A5A5) $display("FAIL flush_ex_drop got %h want %h", lo, 32'h0000_A5A5); else n_pass++;
    md_start = 1; tick();
    md_start = 0; flush = 1; tick();
    flush = 0; md_done = 1; md_result = 64'hDEAD_BEEF_CAFE_F00D; tick();
    md_done = 0; tick(); tick();
    n_total++; if ({hi, lo} !== 64'h0000_0007_0000_A5A5) $display("FAIL flush_md_kill got %h want %h", {hi, lo}, 64'h0000_0007_0000_A5A5); else n_pass++;
    rd_req = 1; #1;
    n_total++; if (stall_req !== 1'b0) $display("FAIL flush_busy got %b want 0", stall_req); else n_pass++;
    rd_req = 0;
    md_start = 1; tick();
    md_start = 0; md_done = 1; flush = 1; md_result = 64'hDEAD_BEEF_CAFE_F00D; tick();
    md_done = 0; flush = 0; rd_req = 1; #1;
    n_total++; if (stall_req !== 1'b0) $display("FAIL doneflush_busy got %b want 0", stall_req); else n_pass++;
    rd_req = 0; tick(); tick();
    n_total++; if ({hi, lo} !== 64'h0000_0007_0000_A5A5) $display("FAIL doneflush_drop got %h want %h", {hi, lo}, 64'h0000_0007_0000_A5A5); else n_pass++;
  endtask

  task automatic test_stall_all();
    mt_we_hi = 1; mt_data = 32'h11; tick();
    mt_we_hi = 0; mt_we_lo = 1; mt_data = 32'h22; tick();
    mt_we_lo = 0; stall_all = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++; if (hi !== 32'h7) $display("FAIL freeze_hi%0d got %h want %h", i, hi, 32'h7); else n_pass++;
      n_total++; if (lo !== 32'h0000_A5A5) $display("FAIL freeze_lo%0d got %h want %h", i, lo, 32'h0000_A5A5); else n_pass++;
    end
    rd_req = 1; rd_sel = 0; #1;
    n_total++; if (rd_data !== 32'h22) $display("FAIL freeze_fwd got %h want %h", rd_data, 32'h22); else n_pass++;
    rd_req = 0; stall_all = 0; tick();
    n_total++; if ({hi, lo} !== 64'h0000_0011_0000_A5A5) $display("FAIL resume1 got %h want %h", {hi, lo}, 64'h0000_0011_0000_A5A5); else n_pass++;
    tick();
    n_total++; if (lo !== 32'h22) $display("FAIL resume2 got %h want %h", lo, 32'h22); else n_pass++;
    md_start = 1; tick();
    md_start = 0; stall_all = 1; md_done = 1; md_result = 64'h0000_0033_0000_0044; tick(); tick();
    rd_req = 1; #1;
    n_total++; if (stall_req !== 1'b1) $display("FAIL freeze_busy got %b want 1", stall_req); else n_pass++;
    rd_req = 0; stall_all = 0; tick();
    md_done = 0; tick(); tick();
    n_total++; if ({hi, lo} !== 64'h0000_0033_0000_0044) $display("FAIL freeze_done got %h want %h", {hi, lo}, 64'h0000_0033_0000_0044); else n_pass++;
  endtask

  task automatic test_reset_mid();
    md_start = 1; tick();
    md_start = 0; tick();
    rst = 0; rd_req = 1; rd_sel = 1; #1;
    n_total++; if ({hi, lo} !== 64'h0) $display("FAIL rstmid_hilo got %h want %h", {hi, lo}, 64'h0); else n_pass++;
    n_total++; if (stall_req !== 1'b0) $display("FAIL rstmid_stall got %b want 0", stall_req); else n_pass++;
    n_total++; if (rd_data !== 32'h0) $display("FAIL rstmid_rd got %h want %h", rd_data, 32'h0); else n_pass++;
    rst = 1; md_done = 1; md_result = 64'h5; tick();
    md_done = 0; rd_req = 0; tick(); tick();
    n_total++; if ({hi, lo} !== 64'h0) $display("FAIL rstmid_ignore got %h want %h", {hi, lo}, 64'h0); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_basic_write();
    test_stall_on_busy();
    test_madd_msub();
    test_mt_forward();
    test_flush();
    test_stall_all();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
